// File: rtl/scandoubler_ctrl.sv
// rtl/scandoubler_ctrl.sv - scandoubler sync lock and frame-aligned configuration sequencer
//
// Purpose:
//   Measures the hsync line period and locks onto a stable source.
//   Classifies the source as 15 kHz or 31 kHz.
//   Shadows the user video settings and commits them only at a frame boundary
//   once locked, so the scandoubler never changes mode mid-frame.
//
// Optional feature macro: SCANDOUBLER_CTRL_AUTO_BYPASS_EN
//   When defined, a locked 31 kHz source (is_15k=0) is bypassed automatically.
//   When undefined, bypass follows only the committed force flag, and is also
//   forced high in NOSYNC.
//
// Ports:
//   clk_sys          in   system clock
//   reset_n          in   asynchronous active-low reset
//   hs_in            in   hsync, active low; a line starts on its falling edge
//   vs_in            in   vsync, active low; a frame starts on its falling edge
//   cfg_valid        in   one-cycle strobe that loads cfg_* into the pending registers
//   cfg_scanlines    in   [1:0] requested scanline strength
//   cfg_ce_divider   in   [2:0] requested pixel-clock divider
//   cfg_force_bypass in   1 forces pass-through
//   bypass           out  pass-through select to the scandoubler
//   ce_divider       out  [2:0] committed divider (0 passed through unchanged)
//   scanlines        out  [1:0] committed scanline strength
//   locked           out  sync is stable
//   line_period      out  [HSCNT_WIDTH-1:0] last measured period, saturating
//   is_15k           out  detection result latched at lock
module scandoubler_ctrl #(
  parameter int HSCNT_WIDTH  = 12,
  parameter int TH_15K       = 1500,
  parameter int TOL          = 8,
  parameter int STABLE_LINES = 16,
  parameter int TIMEOUT      = 4095
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic                   cfg_valid,
  input  logic [1:0]             cfg_scanlines,
  input  logic [2:0]             cfg_ce_divider,
  input  logic                   cfg_force_bypass,
  output logic                   bypass,
  output logic [2:0]             ce_divider,
  output logic [1:0]             scanlines,
  output logic                   locked,
  output logic [HSCNT_WIDTH-1:0] line_period,
  output logic                   is_15k
);

  localparam int MW = $clog2(STABLE_LINES + 1);
  localparam logic [HSCNT_WIDTH-1:0]   CNT_MAX   = '1;
  localparam logic [HSCNT_WIDTH-1:0]   TIMEOUT_C = HSCNT_WIDTH'(TIMEOUT);
  localparam logic [HSCNT_WIDTH-1:0]   TH_C      = HSCNT_WIDTH'(TH_15K);
  localparam logic signed [HSCNT_WIDTH:0] TOL_C  = (HSCNT_WIDTH + 1)'(TOL);
  localparam logic [MW-1:0]            STABLE_C  = MW'(STABLE_LINES);

  typedef enum logic [1:0] {
    S_NOSYNC  = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic                   r_hs_d1, r_hs_d2, r_vs_d1, r_vs_d2;
  logic [HSCNT_WIDTH-1:0] r_cnt;
  logic [HSCNT_WIDTH-1:0] r_line_period;
  logic [MW-1:0]          r_match, w_match_next;
  logic                   r_is_15k, w_is_15k_next;
  logic                   r_locked;
  logic [1:0]             r_pend_scan, r_scan, w_scan_next;
  logic [2:0]             r_pend_ce, r_ce, w_ce_next;
  logic                   r_pend_force, r_force, w_force_next;
  logic                   r_bypass;

  logic                          w_hs_fall, w_vs_fall, w_cnt_sat, w_match, w_commit, w_auto;
  logic [HSCNT_WIDTH-1:0]        w_period_new;
  logic signed [HSCNT_WIDTH:0]   w_diff, w_absdiff;

  // Edge registers reset low so a source that is already low at reset
  // release is not mistaken for a falling edge.
  assign w_hs_fall = r_hs_d2 & ~r_hs_d1;
  assign w_vs_fall = r_vs_d2 & ~r_vs_d1;

  // The counter is cleared on the edge cycle itself, so the cycle count
  // between edges is r_cnt + 1; a saturated counter reports all-ones.
  assign w_cnt_sat    = (r_cnt == CNT_MAX);
  assign w_period_new = w_cnt_sat ? CNT_MAX : r_cnt + 1'b1;

  assign w_diff    = $signed({1'b0, w_period_new}) - $signed({1'b0, r_line_period});
  assign w_absdiff = w_diff[HSCNT_WIDTH] ? -w_diff : w_diff;
  assign w_match   = (w_period_new != CNT_MAX) && (w_absdiff <= TOL_C);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_NOSYNC;
      r_match  <= '0;
      r_is_15k <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_match  <= w_match_next;
      r_is_15k <= w_is_15k_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_match_next  = r_match;
    w_is_15k_next = r_is_15k;
    if (w_hs_fall) begin
      case (r_state)
        S_NOSYNC: begin
          w_state_next = S_MEASURE;
          w_match_next = '0;
        end
        S_MEASURE: begin
          if (w_match) begin
            w_match_next = r_match + 1'b1;
            if (r_match + 1'b1 == STABLE_C) begin
              w_state_next  = S_LOCKED;
              w_is_15k_next = (w_period_new >= TH_C);
            end
          end else begin
            w_match_next = '0;
          end
        end
        S_LOCKED: begin
          if (!w_match) begin
            w_state_next = S_MEASURE;
            w_match_next = '0;
          end
        end
        default: begin
          w_state_next = S_NOSYNC;
          w_match_next = '0;
        end
      endcase
    end else if (r_cnt == TIMEOUT_C) begin
      w_state_next = S_NOSYNC;
    end
  end

  // Without a lock there is no frame to protect, so pending values flow
  // straight through; once locked they wait for the frame start.
  assign w_commit     = (r_state != S_LOCKED) || w_vs_fall;
  assign w_scan_next  = w_commit ? r_pend_scan  : r_scan;
  assign w_ce_next    = w_commit ? r_pend_ce    : r_ce;
  assign w_force_next = w_commit ? r_pend_force : r_force;

`ifdef SCANDOUBLER_CTRL_AUTO_BYPASS_EN
  assign w_auto = (w_state_next == S_LOCKED) && !w_is_15k_next;
`else
  assign w_auto = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_d1       <= 1'b0;
      r_hs_d2       <= 1'b0;
      r_vs_d1       <= 1'b0;
      r_vs_d2       <= 1'b0;
      r_cnt         <= '0;
      r_line_period <= '0;
      r_locked      <= 1'b0;
      r_pend_scan   <= '0;
      r_pend_ce     <= '0;
      r_pend_force  <= 1'b0;
      r_scan        <= '0;
      r_ce          <= '0;
      r_force       <= 1'b0;
      r_bypass      <= 1'b1;
    end else begin
      r_hs_d1 <= hs_in;
      r_hs_d2 <= r_hs_d1;
      r_vs_d1 <= vs_in;
      r_vs_d2 <= r_vs_d1;

      if (w_hs_fall) begin
        r_line_period <= w_period_new;
        r_cnt         <= '0;
      end else if (!w_cnt_sat) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // The commit above reads the pending value from before this strobe,
      // so a strobe on the commit cycle lands one frame later.
      if (cfg_valid) begin
        r_pend_scan  <= cfg_scanlines;
        r_pend_ce    <= cfg_ce_divider;
        r_pend_force <= cfg_force_bypass;
      end

      r_scan   <= w_scan_next;
      r_ce     <= w_ce_next;
      r_force  <= w_force_next;
      r_locked <= (w_state_next == S_LOCKED);
      r_bypass <= (w_state_next == S_NOSYNC) || w_force_next || w_auto;
    end
  end

  assign bypass      = r_bypass;
  assign ce_divider  = r_ce;
  assign scanlines   = r_scan;
  assign locked      = r_locked;
  assign line_period = r_line_period;
  assign is_15k      = r_is_15k;

endmodule

// File: tb/tb_scandoubler_ctrl.sv
// tb/tb_scandoubler_ctrl.sv - self-checking bench for scandoubler_ctrl
module tb_scandoubler_ctrl;

  localparam int W = 12;

`ifdef SCANDOUBLER_CTRL_AUTO_BYPASS_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic           clk_sys = 1'b0;
  logic           reset_n;
  logic           hs_in, vs_in, cfg_valid, cfg_force_bypass;
  logic [1:0]     cfg_scanlines;
  logic [2:0]     cfg_ce_divider;
  logic           bypass, locked, is_15k;
  logic [2:0]     ce_divider;
  logic [1:0]     scanlines;
  logic [W-1:0]   line_period;

  int n_checks = 0;
  int n_errors = 0;
  int since_edge = 0;

  // Line-level reference: one update per hsync falling edge.
  localparam int M_NOSYNC = 0, M_MEASURE = 1, M_LOCKED = 2;
  int m_state, m_prev, m_cnt, m_lp;
  bit m_15k, m_force;

  typedef struct {
    int gap;
    int exp_lp;
    bit exp_locked;
    bit exp_15k;
    bit exp_bypass;
  } row_t;
  row_t tbl[18];

  scandoubler_ctrl dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .hs_in            (hs_in),
    .vs_in            (vs_in),
    .cfg_valid        (cfg_valid),
    .cfg_scanlines    (cfg_scanlines),
    .cfg_ce_divider   (cfg_ce_divider),
    .cfg_force_bypass (cfg_force_bypass),
    .bypass           (bypass),
    .ce_divider       (ce_divider),
    .scanlines        (scanlines),
    .locked           (locked),
    .line_period      (line_period),
    .is_15k           (is_15k)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      since_edge++;
    end
  endtask

  function automatic void model_reset();
    m_state = M_NOSYNC;
    m_prev  = 0;
    m_cnt   = 0;
    m_lp    = 0;
    m_15k   = 1'b0;
    m_force = 1'b0;
  endfunction

  function automatic void model_edge(input int gap);
    int p;
    int d;
    bit match;
    p = (gap >= 4095) ? 4095 : gap;
    if (gap > 4096) m_state = M_NOSYNC;
    d = p - m_prev;
    if (d < 0) d = -d;
    match = (p != 4095) && (d <= 8);
    case (m_state)
      M_NOSYNC: begin
        m_state = M_MEASURE;
        m_cnt   = 0;
      end
      M_MEASURE: begin
        m_cnt = match ? m_cnt + 1 : 0;
        if (m_cnt == 16) begin
          m_state = M_LOCKED;
          m_15k   = (p >= 1500);
        end
      end
      default: begin
        if (!match) begin
          m_state = M_MEASURE;
          m_cnt   = 0;
        end
      end
    endcase
    m_prev = p;
    m_lp   = p;
  endfunction

  function automatic int exp_bypass();
    return int'((m_state == M_NOSYNC) || m_force || (AUTO && m_state == M_LOCKED && !m_15k));
  endfunction

  task automatic hs_fall();
    hs_in = 1'b0;
    model_edge(since_edge);
    since_edge = 0;
  endtask

  task automatic do_line(input int gap);
    hs_fall();
    tick(32);
    hs_in = 1'b1;
    tick(gap - 32);
  endtask

  task automatic check_model(input string tag);
    if (since_edge > 4097) m_state = M_NOSYNC;
    check({tag, "_locked"}, int'(locked), int'(m_state == M_LOCKED));
    check({tag, "_is15k"},  int'(is_15k), int'(m_15k));
    check({tag, "_lp"},     int'(line_period), m_lp);
    check({tag, "_bypass"}, int'(bypass), exp_bypass());
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bypass"}, int'(bypass), 1);
    check({tag, "_ce"},     int'(ce_divider), 0);
    check({tag, "_scan"},   int'(scanlines), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_lp"},     int'(line_period), 0);
    check({tag, "_is15k"},  int'(is_15k), 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, c;

    // First edge measures the 200 idle cycles after reset (+2 pipeline);
    // then 16 matches at 1500 (exactly the 15 kHz threshold) lock on row 17.
    for (int k = 0; k < 18; k++)
      tbl[k] = '{1500, (k == 0) ? 202 : 1500, (k >= 17), (k >= 17), 1'b0};

    reset_n = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1;
    cfg_valid = 1'b0; cfg_scanlines = '0; cfg_ce_divider = '0; cfg_force_bypass = 1'b0;
    model_reset();
    tick(3);
    check_reset_values("reset");

    reset_n = 1'b1;
    since_edge = 2;
    tick(200);
    check("idle_bypass", int'(bypass), 1);
    check("idle_locked", int'(locked), 0);

    for (int k = 0; k < 18; k++) begin
      do_line(tbl[k].gap);
      check($sformatf("tbl%0d_locked", k), int'(locked), int'(tbl[k].exp_locked));
      check($sformatf("tbl%0d_is15k", k),  int'(is_15k), int'(tbl[k].exp_15k));
      check($sformatf("tbl%0d_lp", k),     int'(line_period), tbl[k].exp_lp);
      check($sformatf("tbl%0d_bypass", k), int'(bypass), int'(tbl[k].exp_bypass));
    end

    // Frame-aligned commit while locked.
    hs_fall();
    tick(32);
    hs_in = 1'b1;
    tick(20);
    cfg_valid = 1'b1; cfg_scanlines = 2'd2; cfg_ce_divider = 3'd7; cfg_force_bypass = 1'b0;
    tick(1);
    cfg_valid = 1'b0;
    tick(10);
    check("midframe_scan", int'(scanlines), 0);
    check("midframe_ce", int'(ce_divider), 0);
    vs_in = 1'b0;
    tick(1);
    check("vs1_scan", int'(scanlines), 0);
    check("vs1_ce", int'(ce_divider), 0);
    tick(1);
    check("vs2_scan", int'(scanlines), 2);
    check("vs2_ce", int'(ce_divider), 7);
    tick(4);
    vs_in = 1'b1;
    tick(20);
    cfg_valid = 1'b1; cfg_scanlines = 2'd3; cfg_ce_divider = 3'd5; cfg_force_bypass = 1'b0;
    tick(1);
    cfg_valid = 1'b0;
    tick(10);
    check("pend_hold_scan", int'(scanlines), 2);
    check("pend_hold_ce", int'(ce_divider), 7);
    vs_in = 1'b0;
    tick(1);
    cfg_valid = 1'b1; cfg_scanlines = 2'd1; cfg_ce_divider = 3'd3; cfg_force_bypass = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    check("same_cycle_scan", int'(scanlines), 3);
    check("same_cycle_ce", int'(ce_divider), 5);
    check("same_cycle_bypass", int'(bypass), 0);
    tick(4);
    vs_in = 1'b1;
    tick(20);
    check("frame_stable_scan", int'(scanlines), 3);
    check("frame_stable_ce", int'(ce_divider), 5);
    vs_in = 1'b0;
    tick(2);
    m_force = 1'b1;
    check("next_frame_scan", int'(scanlines), 1);
    check("next_frame_ce", int'(ce_divider), 3);
    check("next_frame_bypass", int'(bypass), 1);
    tick(4);
    vs_in = 1'b1;
    tick(1500 - since_edge);
    check_model("cfgline");

    // One long line breaks the lock; is_15k must hold, then relock on jitter.
    do_line(1520);
    check_model("glitch_pre");
    do_line(1500);
    check_model("glitch");
    check("glitch_unlock", int'(locked), 0);
    check("glitch_15k_hold", int'(is_15k), 1);
    for (int i = 0; i < 17; i++) begin
      do_line((i == 0) ? 1508 : int'($urandom_range(1500, 1508)));
      check_model($sformatf("jit%0d", i));
    end
    check("relock", int'(locked), 1);

    // Loss of sync.
    hs_fall();
    tick(32);
    hs_in = 1'b1;
    tick(4200);
    check_model("timeout");
    check("timeout_locked", int'(locked), 0);
    check("timeout_bypass", int'(bypass), 1);
    s = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 7));
    cfg_valid = 1'b1; cfg_scanlines = 2'(s); cfg_ce_divider = 3'(c); cfg_force_bypass = 1'b0;
    tick(1);
    cfg_valid = 1'b0;
    tick(1);
    m_force = 1'b0;
    check("nosync_commit_scan", int'(scanlines), s);
    check("nosync_commit_ce", int'(ce_divider), c);
    check("nosync_bypass", int'(bypass), 1);

    // 31 kHz source.
    for (int i = 0; i < 19; i++) begin
      do_line((i == 0) ? 600 : int'($urandom_range(600, 604)));
      check_model($sformatf("k31_%0d", i));
    end
    check("k31_locked", int'(locked), 1);
    check("k31_is15k", int'(is_15k), 0);
    check("k31_bypass", int'(bypass), int'(AUTO));
    check("k31_scan", int'(scanlines), s);
    check("k31_ce", int'(ce_divider), c);

    // Reset in the middle of a line.
    hs_fall();
    tick(100);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    tick(2);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
